// File: rtl/mmm_core.sv
// rtl/mmm_core.sv - bit-serial Montgomery modular multiplier, r = a*b*2^-WIDTH mod m
module mmm_core #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, SUB} state_t;

  state_t           state, state_nx;
  logic [WIDTH+1:0] acc, acc_nx, sum, b_w, m_w;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] a_l, a_nx, b_l, b_nx, m_l, m_nx, r_nx, diff;
  logic             done_nx, err_nx, q;

  // a_l is shifted right every iteration so bit 0 is always the current multiplier bit
  assign b_w  = {2'b00, b_l};
  assign m_w  = {2'b00, m_l};
  assign q    = acc[0] ^ (a_l[0] & b_l[0]);
  assign sum  = acc + (a_l[0] ? b_w : '0) + (q ? m_w : '0);
  assign diff = acc[WIDTH-1:0] - m_l;
  assign busy = (state == ITER) || (state == SUB);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    a_nx     = a_l;
    b_nx     = b_l;
    m_nx     = m_l;
    r_nx     = r;
    err_nx   = err;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (m[0]) begin
            a_nx     = a;
            b_nx     = b;
            m_nx     = m;
            acc_nx   = '0;
            cnt_nx   = '0;
            err_nx   = 1'b0;
            state_nx = ITER;
          end else begin
            err_nx  = 1'b1;
            done_nx = 1'b1;
          end
        end
      end
      ITER: begin
        acc_nx = sum >> 1;
        a_nx   = a_l >> 1;
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) state_nx = SUB;
      end
      SUB: begin
        // acc < 2m here, so a single conditional subtraction lands in [0, m)
        r_nx     = (acc >= m_w) ? diff : acc[WIDTH-1:0];
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      a_l   <= '0;
      b_l   <= '0;
      m_l   <= '0;
      r     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      a_l   <= a_nx;
      b_l   <= b_nx;
      m_l   <= m_nx;
      r     <= r_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

endmodule
